hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
EX-stage HI/LO execution unit for the 5-stage MIPS pipeline. It owns the architectural HI and LO registers and executes MULT/MULTU (fixed 1-cycle iteration) and DIV/DIVU (iterative restoring, WIDTH+1 cycles). It serves MTHI/MTLO/MFHI/MFLO and drives hl_dout, which is carried down the pipe as the MEM/WB HL value consumed by the HL/CP0 forwarding mux. It stalls the EX stage when an HL op meets an in-flight operation.

Parameters:
WIDTH, 32, operand/HI/LO width; divide iteration count equals WIDTH.

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous active-high reset
ex_valid  input  1  EX instruction valid and not bubbled
ex_hlop  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, others = NONE
ex_a  input  WIDTH  rs operand, already forwarded
ex_b  input  WIDTH  rt operand, already forwarded
flush  input  1  exception/ERET flush; cancels the in-flight op and the EX op
stall_req  output  1  hold IF/ID/EX this cycle
busy  output  1  mul/div in flight
hl_dout  output  WIDTH  MFHI→HI, MFLO→LO, else 0 (combinational)
hi  output  WIDTH  architectural HI
lo  output  WIDTH  architectural LO

Behaviour:
- Reset: state IDLE; hi, lo, operand/partial registers = 0; busy = 0, stall_req = 0.
- Reset mid-operation: abort immediately, no HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- Accept condition: state IDLE, ex_valid, flush = 0, op ≠ NONE.
- IDLE with MULT/MULTU: latch operands and signedness, go to MUL.
- IDLE with DIV/DIVU: latch absolute values (signed) or raw values (unsigned), record quotient and remainder signs, set count = 0, go to DIV.
- IDLE with MTHI/MTLO: write hi/lo at that edge, stay IDLE.
- MFHI/MFLO: read only.
- MUL, 1 cycle: form the 2·WIDTH product (signed or unsigned). At the exit edge write hi = upper half, lo = lower half, then go to IDLE.
- DIV: one restoring step per cycle for WIDTH cycles (shift remainder left, subtract divisor, set quotient bit if result ≥ 0). After count reaches WIDTH−1, go to FIX.
- FIX, 1 cycle: apply signs (quotient negated if operand signs differ, remainder takes dividend sign). Write lo = quotient, hi = remainder, then go to IDLE.
- Divide by zero: the algorithm runs unchanged. Required result is lo = all-ones and hi = dividend; verify exactly this.
- Latency from accept edge T: MULT results are visible in hi/lo at T+2. DIV results are visible at T+WIDTH+2 (34 for WIDTH=32).
- busy = (state ≠ IDLE).
- stall_req = busy AND ex_valid AND op ≠ NONE AND NOT flush. Non-HL instructions proceed under busy.
- No result bypass: an MFHI issued right after a MULT stalls until the state returns to IDLE, then reads the committed value.
- flush while busy: return to IDLE at the next edge with hi/lo unchanged. flush in IDLE: the EX op is not accepted and MTHI/MTLO do not write.
- The issuing mul/div itself is not stalled; EX advances on its accept cycle.
- Arithmetic: signed MIN/−1 yields quotient MIN and remainder 0 (wraps), with no exception.

Decomposition:
- Shared package: HL op encodings, state encodings, WIDTH default.
- One sub-module, div_restoring_step: combinational single-step shift/subtract, WIDTH-parameterised.
- Multiply stays inline.

Test Plan:
- MULT a=0xFFFFFFFF, b=2 → after 2 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=−7 (0xFFFFFFF9), b=2 → at T+34 lo=0xFFFFFFFD, hi=0xFFFFFFFF. busy high for exactly 33 cycles.
- DIVU a=100, b=7 → lo=14, hi=2. MFHI presented on the cycle after accept → stall_req high every busy cycle, then hl_dout=2 on the first IDLE cycle.
- DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5. MTLO 0x1234 followed by MFLO → hl_dout=0x1234 with no stall.
- Start DIVU with hi=lo=0xAA, assert flush at cycle 10 → busy drops the next cycle and hi=lo=0xAA. Repeat with rst at cycle 10 → all zero.
- ADD (op NONE) issued while busy → stall_req=0. MTHI while busy → stalled; hi is written only after the DIV completes, and hi finally holds the MTHI value.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: HL op encodings, unit states and default width
package hilo_muldiv_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [3:0] {
    HL_NONE  = 4'd0,
    HL_MULT  = 4'd1,
    HL_MULTU = 4'd2,
    HL_DIV   = 4'd3,
    HL_DIVU  = 4'd4,
    HL_MTHI  = 4'd5,
    HL_MTLO  = 4'd6,
    HL_MFHI  = 4'd7,
    HL_MFLO  = 4'd8
  } hl_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;
endpackage

// File: rtl/hilo_muldiv_unit_div_restoring_step.sv
// div_restoring_step: one combinational shift/subtract step of restoring division
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] sh, diff;
  assign sh    = {rem, quo[WIDTH-1]};
  assign diff  = sh - {1'b0, dvs};
  assign rem_n = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: EX-stage HI/LO owner with 1-cycle multiply and iterative divide
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_hlop,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic [WIDTH-1:0] hl_dout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_e state, state_d;
  logic [WIDTH-1:0] op_a, op_b, rem, rem_n, quo_n, abs_a, abs_b;
  logic [2*WIDTH-1:0] ax, bx, prod;
  logic [CW-1:0] count;
  logic sg, q_neg, r_neg, is_hl, is_mul, is_div, accept, a_neg, b_neg;
  assign is_hl  = ex_hlop != HL_NONE && ex_hlop <= HL_MFLO;
  assign is_mul = ex_hlop == HL_MULT || ex_hlop == HL_MULTU;
  assign is_div = ex_hlop == HL_DIV || ex_hlop == HL_DIVU;
  assign accept = state == S_IDLE && ex_valid && !flush && is_hl;
  assign busy = state != S_IDLE;
  assign stall_req = busy && ex_valid && is_hl && !flush;
  assign hl_dout = ex_hlop == HL_MFHI ? hi : ex_hlop == HL_MFLO ? lo : '0;
  assign a_neg = ex_hlop == HL_DIV && ex_a[WIDTH-1];
  assign b_neg = ex_hlop == HL_DIV && ex_b[WIDTH-1];
  assign abs_a = a_neg ? -ex_a : ex_a;
  assign abs_b = b_neg ? -ex_b : ex_b;
  assign ax = {{WIDTH{sg & op_a[WIDTH-1]}}, op_a};
  assign bx = {{WIDTH{sg & op_b[WIDTH-1]}}, op_b};
  assign prod = ax * bx;
  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem), .quo(op_a), .dvs(op_b), .rem_n(rem_n), .quo_n(quo_n)
  );
  always_comb begin
    state_d = state;
    if (flush) state_d = S_IDLE;
    else if (accept) state_d = is_mul ? S_MUL : is_div ? S_DIV : S_IDLE;
    else if (state == S_MUL || state == S_FIX) state_d = S_IDLE;
    else if (state == S_DIV && count == CW'(WIDTH-1)) state_d = S_FIX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      rem   <= '0;
      count <= '0;
      sg    <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      state <= state_d;
      if (!flush) begin
        case (state)
          S_IDLE: if (accept) begin
            if (is_mul) begin
              op_a <= ex_a;
              op_b <= ex_b;
              sg   <= ex_hlop == HL_MULT;
            end
            if (is_div) begin
              op_a  <= abs_a;
              op_b  <= abs_b;
              rem   <= '0;
              count <= '0;
              q_neg <= (a_neg ^ b_neg) & |ex_b;
              r_neg <= a_neg;
            end
            if (ex_hlop == HL_MTHI) hi <= ex_a;
            if (ex_hlop == HL_MTLO) lo <= ex_a;
          end
          S_MUL: begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          S_DIV: begin
            rem   <= rem_n;
            op_a  <= quo_n;
            count <= count + 1'b1;
          end
          default: begin
            lo <= q_neg ? -op_a : op_a;
            hi <= r_neg ? -rem : rem;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scenario tasks with a {hi,lo} result scoreboard
module tb_hilo_muldiv_unit;
  import hilo_muldiv_pkg::*;
  logic clk = 0, rst = 1, ex_valid = 0, flush = 0;
  logic [3:0] ex_hlop = 0;
  logic [31:0] ex_a = 0, ex_b = 0;
  logic stall_req, busy;
  logic [31:0] hl_dout, hi, lo;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  int checks = 0, errors = 0;
  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_hlop(ex_hlop), .ex_a(ex_a),
    .ex_b(ex_b), .flush(flush), .stall_req(stall_req), .busy(busy),
    .hl_dout(hl_dout), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1; ex_hlop = op; ex_a = a; ex_b = b;
    step(1);
    ex_valid = 0; ex_hlop = HL_NONE;
  endtask
  task wait_idle(output int cyc, output bit to);
    cyc = 0;
    while (busy && cyc < 100) begin
      step(1);
      cyc++;
    end
    to = busy;
  endtask
  task test_reset;
    rst = 1;
    step(2);
    rst = 0;
    ex_hlop = HL_MFHI;
    #1;
    checks++;
    if ({busy, stall_req, hi, lo, hl_dout} !== 98'd0) begin
      errors++;
      $display("FAIL reset busy=%b stall=%b hi=%h lo=%h dout=%h want all 0", busy, stall_req, hi, lo, hl_dout);
    end
    ex_hlop = HL_NONE;
  endtask
  task test_mult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] r);
    int cyc; bit to;
    issue(op, a, b);
    exp_q.push_back(r);
    wait_idle(cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || cyc != 1) begin
      errors++;
      $display("FAIL mult_latency busy_cycles=%0d want 1", cyc);
    end
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL mult_result op=%0d hi:lo=%h want %h", op, {hi, lo}, e);
    end
  endtask
  task test_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] r);
    int cyc; bit to;
    issue(op, a, b);
    exp_q.push_back(r);
    wait_idle(cyc, to);
    e = exp_q.pop_front();
    checks++;
    if (to || cyc != 33) begin
      errors++;
      $display("FAIL div_busy_cycles got=%0d want 33", cyc);
    end
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL div_result a=%h b=%h hi:lo=%h want %h", a, b, {hi, lo}, e);
    end
  endtask
  task test_divu_mfhi;
    int cyc; bit bad;
    issue(HL_DIVU, 32'd100, 32'd7);
    exp_q.push_back({32'd2, 32'd14});
    ex_valid = 1; ex_hlop = HL_MFHI;
    cyc = 0; bad = 0;
    while (busy && cyc < 100) begin
      if (stall_req !== 1'b1) bad = 1;
      step(1);
      cyc++;
    end
    checks++;
    if (bad || busy) begin
      errors++;
      $display("FAIL mfhi_stall stall dropped while busy or timeout cyc=%0d", cyc);
    end
    checks++;
    if (stall_req !== 1'b0 || hl_dout !== 32'd2) begin
      errors++;
      $display("FAIL mfhi_read stall=%b dout=%h want 0 / 2", stall_req, hl_dout);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL divu_result hi:lo=%h want %h", {hi, lo}, e);
    end
    step(1);
    ex_valid = 0; ex_hlop = HL_NONE;
  endtask
  task test_mtlo_mflo;
    issue(HL_MTLO, 32'h1234, 32'd0);
    ex_valid = 1; ex_hlop = HL_MFLO;
    #1;
    checks++;
    if (hl_dout !== 32'h1234 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_mflo dout=%h stall=%b want 1234 / 0", hl_dout, stall_req);
    end
    step(1);
    ex_valid = 0; ex_hlop = HL_NONE;
  endtask
  task test_flush;
    issue(HL_MTHI, 32'hAA, 0);
    issue(HL_MTLO, 32'hAA, 0);
    issue(HL_DIVU, 32'd1000, 32'd3);
    step(9);
    flush = 1;
    step(1);
    flush = 0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'hAA || lo !== 32'hAA) begin
      errors++;
      $display("FAIL flush_busy busy=%b hi=%h lo=%h want 0 aa aa", busy, hi, lo);
    end
    step(40);
    checks++;
    if (hi !== 32'hAA || lo !== 32'hAA) begin
      errors++;
      $display("FAIL flush_late hi=%h lo=%h want aa aa", hi, lo);
    end
    ex_valid = 1; ex_hlop = HL_MTHI; ex_a = 32'h55; flush = 1;
    step(1);
    ex_valid = 0; ex_hlop = HL_NONE; flush = 0;
    checks++;
    if (hi !== 32'hAA || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_mthi hi=%h want aa", hi);
    end
  endtask
  task test_rst_abort;
    issue(HL_MTHI, 32'hAA, 0);
    issue(HL_MTLO, 32'hAA, 0);
    issue(HL_DIVU, 32'd1000, 32'd3);
    step(9);
    rst = 1;
    step(1);
    rst = 0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL rst_abort busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    step(40);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL rst_late hi=%h lo=%h want 0 0", hi, lo);
    end
  endtask
  task test_back_to_back;
    int cyc;
    issue(HL_DIVU, 32'd50, 32'd5);
    exp_q.push_back({32'd0, 32'd10});
    ex_valid = 1; ex_hlop = HL_NONE;
    #1;
    checks++;
    if (stall_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_no_stall stall=%b busy=%b want 0 1", stall_req, busy);
    end
    ex_hlop = HL_MTHI; ex_a = 32'h77;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      errors++;
      $display("FAIL mthi_stall stall=%b want 1", stall_req);
    end
    cyc = 0;
    while (busy && cyc < 100) begin
      step(1);
      cyc++;
    end
    e = exp_q.pop_front();
    checks++;
    if (busy || {hi, lo} !== e) begin
      errors++;
      $display("FAIL b2b_div hi:lo=%h want %h", {hi, lo}, e);
    end
    step(1);
    ex_valid = 0; ex_hlop = HL_NONE;
    checks++;
    if (hi !== 32'h77 || lo !== 32'd10) begin
      errors++;
      $display("FAIL b2b_mthi hi=%h lo=%h want 77 0a", hi, lo);
    end
  endtask
  initial begin
    test_reset;
    test_mult(HL_MULT, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE);
    test_mult(HL_MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
    test_mult(HL_MULT, 32'h00012345, 32'hFFFF0000, 64'hFFFFFFFE_DCBB0000);
    test_div(HL_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    test_div(HL_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    test_div(HL_DIV, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
    test_div(HL_DIVU, 32'hF0000001, 32'h10, 64'h00000001_0F000000);
    test_divu_mfhi;
    test_mtlo_mflo;
    test_flush;
    test_rst_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
